// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings and access-legality helpers for the M-stage data memory responder.
package rv32_mem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only encode b/h/w; loads additionally allow bu/hu.
    function automatic logic is_illegal_f3(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return (funct3 > F3_W);
        else
            return !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                     funct3 == F3_BU || funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Load formatter: picks the addressed byte/half from a read word and sign/zero-extends it.
import rv32_mem_pkg::*;

module mem_load_align (
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[8*i_addr_lo +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            F3_W:    o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// M-stage data memory responder: byte/half/word loads and stores against a word array
// with programmable wait states, stalling the pipeline for LATENCY+1 cycles per access.
import rv32_mem_pkg::*;

module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  instr_opcodeM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] rdata2M,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        mem_stall,
    output logic        access_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    mem_state_e r_state, w_next;
    logic [3:0]    r_cnt;
    logic [AW+1:0] r_addr;
    logic [2:0]    r_f3;
    logic [31:0]   r_wdata;
    logic          r_is_load, r_is_store;
    logic [31:0]   r_rword;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_is_load, w_is_store, w_access, w_bad, w_accept, w_do_op;
    logic          w_in_idle, w_op_store;
    logic [AW+1:0] w_op_addr;
    logic [2:0]    w_op_f3;
    logic [31:0]   w_op_data, w_wdata, w_fmt;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    assign w_unused_addr = ^AddrM[31:AW+2];

    assign w_is_load  = (instr_opcodeM == OPC_LOAD);
    assign w_is_store = (instr_opcodeM == OPC_STORE);
    assign w_access   = w_is_load || w_is_store;
    assign w_bad      = w_access && (is_misaligned(funct3M, AddrM[1:0]) ||
                                     is_illegal_f3(w_is_store, funct3M));
    assign w_accept   = !rst && (r_state == IDLE) && w_access && !w_bad;
    assign w_do_op    = !rst && ((w_accept && (LATENCY == 0)) ||
                                 ((r_state == WAIT) && (r_cnt == 4'd1)));

    // With zero latency the array op happens at the accept edge, before capture regs are valid.
    assign w_in_idle  = (r_state == IDLE);
    assign w_op_addr  = w_in_idle ? AddrM[AW+1:0] : r_addr;
    assign w_op_f3    = w_in_idle ? funct3M       : r_f3;
    assign w_op_data  = w_in_idle ? rdata2M       : r_wdata;
    assign w_op_store = w_in_idle ? w_is_store    : r_is_store;
    assign w_idx      = w_op_addr[AW+1:2];

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_op_data;
        case (w_op_f3)
            F3_B: begin
                w_be    = 4'b0001 << w_op_addr[1:0];
                w_wdata = {4{w_op_data[7:0]}};
            end
            F3_H: begin
                w_be    = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_op_data[15:0]}};
            end
            F3_W:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_op) begin
            if (w_op_store) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (w_be[i])
                        r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end else begin
                r_rword <= r_mem[w_idx];
            end
        end
    end

    mem_load_align u_align (
        .i_word    (r_rword),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_f3),
        .o_data    (w_fmt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_f3       <= '0;
            r_wdata    <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= 4'(LATENCY);
            r_addr     <= AddrM[AW+1:0];
            r_f3       <= funct3M;
            r_wdata    <= rdata2M;
            r_is_load  <= w_is_load;
            r_is_store <= w_is_store;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        mem_stall  = 1'b0;
        access_err = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    mem_stall = 1'b1;
                    w_next    = (LATENCY == 0) ? RESP : WAIT;
                end else if (!rst && w_bad) begin
                    access_err = 1'b1;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (r_cnt == 4'd1)
                    w_next = RESP;
            end
            RESP: begin
                w_next = IDLE;
                if (r_is_load) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = w_fmt;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one LATENCY=2 instance and one LATENCY=0 instance,
// load results checked against a queue of expected values.
module tb_data_mem_ctrl;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [6:0]  t_opc   [2];
    logic [2:0]  t_f3    [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wd    [2];
    logic [31:0] o_rdata [2];
    logic        o_rvalid[2];
    logic        o_stall [2];
    logic        o_err   [2];

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst),
        .instr_opcodeM(t_opc[0]), .funct3M(t_f3[0]), .AddrM(t_addr[0]), .rdata2M(t_wd[0]),
        .mem_rdata(o_rdata[0]), .mem_rvalid(o_rvalid[0]), .mem_stall(o_stall[0]), .access_err(o_err[0])
    );

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst),
        .instr_opcodeM(t_opc[1]), .funct3M(t_f3[1]), .AddrM(t_addr[1]), .rdata2M(t_wd[1]),
        .mem_rdata(o_rdata[1]), .mem_rvalid(o_rvalid[1]), .mem_stall(o_stall[1]), .access_err(o_err[1])
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          dsel = 0;
    bit          in_resp = 1'b0;
    logic [31:0] sb_q[$];

    function automatic int lat_of(int s);
        return (s == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        t_opc[dsel]  = o;
        t_f3[dsel]   = f;
        t_addr[dsel] = a;
        t_wd[dsel]   = d;
    endtask

    // New inputs go on while the previous access is in RESP, so back-to-back ops see no gap.
    task automatic settle();
        if (in_resp) begin
            @(posedge clk); #1;
        end else begin
            #1;
        end
    endtask

    task automatic access(input string tag, input logic [6:0] o, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_ld);
        int n;
        logic [31:0] e;
        bit is_ld;
        is_ld = (o == OP_LD);
        drive(o, f, a, d);
        settle();
        if (is_ld) sb_q.push_back(exp_ld);
        n = 0;
        while (o_stall[dsel] === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        chk({tag, " stall_cycles"}, 32'(n), 32'(lat_of(dsel) + 1));
        chk({tag, " rvalid"}, {31'd0, o_rvalid[dsel]}, {31'd0, is_ld});
        if (is_ld) begin
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxxxxxx;
            chk({tag, " rdata"}, o_rdata[dsel], e);
        end
        in_resp = 1'b1;
    endtask

    task automatic idle(input int k);
        drive(OP_ALU, 3'd0, 32'd0, 32'd0);
        repeat (k) begin
            @(posedge clk); #1;
        end
        in_resp = 1'b0;
    endtask

    task automatic bad(input string tag, input logic [6:0] o, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
        drive(o, f, a, d);
        settle();
        chk({tag, " err"},    {31'd0, o_err[dsel]},    32'd1);
        chk({tag, " stall"},  {31'd0, o_stall[dsel]},  32'd0);
        chk({tag, " rvalid"}, {31'd0, o_rvalid[dsel]}, 32'd0);
        drive(OP_ALU, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        chk({tag, " err_cleared"}, {31'd0, o_err[dsel]}, 32'd0);
        in_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dsel = i;
            drive(OP_ALU, 3'd0, 32'd0, 32'd0);
        end
        dsel = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d stall", i),  {31'd0, o_stall[i]},  32'd0);
            chk($sformatf("reset%0d rvalid", i), {31'd0, o_rvalid[i]}, 32'd0);
            chk($sformatf("reset%0d err", i),    {31'd0, o_err[i]},    32'd0);
            chk($sformatf("reset%0d rdata", i),  o_rdata[i],           32'd0);
        end

        dsel = 0;
        access("sw10", OP_ST, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0);
        access("lw10", OP_LD, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF);
        idle(1);

        access("sw20",   OP_ST, 3'd2, 32'h20, 32'h00000000, 32'd0);
        access("sb23",   OP_ST, 3'd0, 32'h23, 32'h00000080, 32'd0);
        access("sh20",   OP_ST, 3'd1, 32'h20, 32'h00001234, 32'd0);
        access("lb23",   OP_LD, 3'd0, 32'h23, 32'd0, 32'hFFFFFF80);
        access("lbu23",  OP_LD, 3'd4, 32'h23, 32'd0, 32'h00000080);
        access("lh20",   OP_LD, 3'd1, 32'h20, 32'd0, 32'h00001234);
        access("lh22",   OP_LD, 3'd1, 32'h22, 32'd0, 32'hFFFF8000);
        access("lhu22",  OP_LD, 3'd5, 32'h22, 32'd0, 32'h00008000);
        access("lw20",   OP_LD, 3'd2, 32'h20, 32'd0, 32'h80001234);

        bad("lw22_mis",  OP_LD, 3'd2, 32'h22, 32'd0);
        bad("sh21_mis",  OP_ST, 3'd1, 32'h21, 32'hFFFFFFFF);
        bad("ld_f3_3",   OP_LD, 3'd3, 32'h20, 32'd0);
        bad("st_f3_4",   OP_ST, 3'd4, 32'h20, 32'hFFFFFFFF);
        access("lw20_keep", OP_LD, 3'd2, 32'h20, 32'd0, 32'h80001234);

        access("sw_alias", OP_ST, 3'd2, 32'h0000_1040, 32'hCAFEF00D, 32'd0);
        access("lw_alias", OP_LD, 3'd2, 32'h40, 32'd0, 32'hCAFEF00D);
        idle(2);

        access("sw30_old", OP_ST, 3'd2, 32'h30, 32'h11111111, 32'd0);
        idle(1);
        drive(OP_ST, 3'd2, 32'h30, 32'hAAAAAAAA);
        #1;
        chk("rstmid stall_idle", {31'd0, o_stall[0]}, 32'd1);
        @(posedge clk); #1;
        chk("rstmid stall_wait", {31'd0, o_stall[0]}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid stall",  {31'd0, o_stall[0]},  32'd0);
        chk("rstmid rvalid", {31'd0, o_rvalid[0]}, 32'd0);
        chk("rstmid rdata",  o_rdata[0],           32'd0);
        drive(OP_ALU, 3'd0, 32'd0, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        in_resp = 1'b0;
        access("lw30_old", OP_LD, 3'd2, 32'h30, 32'd0, 32'h11111111);
        idle(1);

        dsel = 1;
        access("l0 sw0", OP_ST, 3'd2, 32'h0, 32'h01020304, 32'd0);
        access("l0 sw4", OP_ST, 3'd2, 32'h4, 32'h05060708, 32'd0);
        access("l0 lw0", OP_LD, 3'd2, 32'h0, 32'd0, 32'h01020304);
        access("l0 lw4", OP_LD, 3'd2, 32'h4, 32'd0, 32'h05060708);
        access("l0 lh6", OP_LD, 3'd1, 32'h6, 32'd0, 32'h00000506);
        access("l0 lb4", OP_LD, 3'd0, 32'h4, 32'd0, 32'h00000008);
        idle(1);
        bad("l0 sw_mis", OP_ST, 3'd2, 32'h2, 32'd0);
        access("l0 lw0_keep", OP_LD, 3'd2, 32'h0, 32'd0, 32'h01020304);
        idle(1);

        chk("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
